// File: rtl/bitwise_pkg.sv
`default_nettype none
// ============================================================================
// bitwise_pkg
// Shared types and constants for the bitwise result packer block.
// Revision: 1.0 - initial release
// ============================================================================
package bitwise_pkg;

  // Width of one result nibble produced by the gate block.
  localparam int NIB_W = 4;

  // Result select carried alongside each beat.
  typedef enum logic [1:0] {
    OP_AND  = 2'd0,
    OP_NAND = 2'd1,
    OP_OR   = 2'd2,
    OP_NOR  = 2'd3
  } op_e;

  // Packer word state.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage : bitwise_pkg
`default_nettype wire

// File: rtl/bitwise_result_sel.sv
`default_nettype none
// ============================================================================
// bitwise_result_sel
// Combinational 4:1 nibble mux choosing one gate-block result by op.
// Revision: 1.0 - initial release
// ============================================================================
module bitwise_result_sel
  import bitwise_pkg::*;
(
  input  logic [1:0]       sel_op,
  input  logic [NIB_W-1:0] res_and,
  input  logic [NIB_W-1:0] res_nand,
  input  logic [NIB_W-1:0] res_or,
  input  logic [NIB_W-1:0] res_nor,
  output logic [NIB_W-1:0] nib
);

  // Pick the result bus named by the op field.
  always_comb begin
    nib = res_and;
    case (sel_op)
      OP_AND:  nib = res_and;
      OP_NAND: nib = res_nand;
      OP_OR:   nib = res_or;
      OP_NOR:  nib = res_nor;
      default: nib = res_and;
    endcase
  end

endmodule : bitwise_result_sel
`default_nettype wire

// File: rtl/bitwise_result_packer.sv
`default_nettype none
// ============================================================================
// bitwise_result_packer
// Packs NBEATS selected result nibbles into one word behind valid/ready
// handshakes on both sides; a flush closes a partial word early.
// NBEATS is meaningful in the range 2..8.
// Revision: 1.0 - initial release
// ============================================================================
module bitwise_result_packer
  import bitwise_pkg::*;
#(
  parameter int NBEATS = 4,
  localparam int CW    = $clog2(NBEATS + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_val,
  output logic                    in_rdy,
  input  logic [1:0]              in_op,
  input  logic [NIB_W-1:0]        in_and,
  input  logic [NIB_W-1:0]        in_nand,
  input  logic [NIB_W-1:0]        in_or,
  input  logic [NIB_W-1:0]        in_nor,
  input  logic                    in_flush,
  output logic                    out_val,
  input  logic                    out_rdy,
  output logic [NIB_W*NBEATS-1:0] out_msg,
  output logic [CW-1:0]           out_count,
  output logic [1:0]              out_op,
  output logic                    out_mixed
);

  state_e                    state, state_nx;
  logic [CW-1:0]             count, count_nx, base_cnt;
  logic [NIB_W*NBEATS-1:0]   word, word_nx, base_word;
  logic [1:0]                op_lat, op_nx, base_op;
  logic                      mixed, mixed_nx, base_mixed;
  logic [NIB_W-1:0]          sel_nib;
  logic                      take, fire;

  bitwise_result_sel u_sel (
    .sel_op   (in_op),
    .res_and  (in_and),
    .res_nand (in_nand),
    .res_or   (in_or),
    .res_nor  (in_nor),
    .nib      (sel_nib)
  );

  // A full word accepts a new beat only in the cycle it drains.
  assign in_rdy    = (state != FULL) || out_rdy;
  assign out_val   = (state == FULL);
  assign take      = in_val && in_rdy;
  assign fire      = out_val && out_rdy;
  assign out_msg   = word;
  assign out_count = count;
  assign out_op    = op_lat;
  assign out_mixed = mixed;

  // Next-state: a draining word restarts from a cleared base, then any beat lands in slot [count].
  always_comb begin
    base_word  = word;
    base_cnt   = count;
    base_op    = op_lat;
    base_mixed = mixed;
    if (fire) begin
      base_word  = '0;
      base_cnt   = '0;
      base_op    = '0;
      base_mixed = 1'b0;
    end
    word_nx  = base_word;
    count_nx = base_cnt;
    op_nx    = base_op;
    mixed_nx = base_mixed;
    state_nx = state;

    if (!(state == FULL && !fire)) begin
      if (take) begin
        for (int k = 0; k < NBEATS; k++) begin
          if (base_cnt == CW'(k)) begin
            word_nx[k*NIB_W +: NIB_W] = sel_nib;
          end
        end
        count_nx = base_cnt + CW'(1);
        if (base_cnt == '0) begin
          op_nx    = in_op;
          mixed_nx = 1'b0;
        end else if (in_op != base_op) begin
          mixed_nx = 1'b1;
        end
      end

      // Flush only closes a word that has content and is not already presented.
      if (count_nx == CW'(NBEATS)) begin
        state_nx = FULL;
      end else if (in_flush && (state != FULL) && (count_nx != '0)) begin
        state_nx = FULL;
      end else if (count_nx != '0) begin
        state_nx = FILL;
      end else begin
        state_nx = EMPTY;
      end
    end
  end

  // State and word registers; reset discards any partial word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      count <= '0;
      word  <= '0;
      op_lat <= '0;
      mixed <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      word  <= word_nx;
      op_lat <= op_nx;
      mixed <= mixed_nx;
    end
  end

endmodule : bitwise_result_packer
`default_nettype wire

// File: doc/bitwise_result_packer.md
# bitwise_result_packer

Downstream stage of the 4-bit bitwise gate block. Each cycle it takes the gate block's four result buses (and, nand, or, nor) plus a valid/ready handshake and an op select. It keeps the selected 4-bit nibble and packs NBEATS consecutive nibbles into one wide word. That word is presented on a latency-insensitive valid/ready output interface to the next stage. A flush input closes a partially filled word early.

## Interface
- NBEATS, 4, nibbles per output word; legal range 2..8
- clk  input  1  clock; one clock, all state on rising edge
- reset_n  input  1  reset is asynchronous and active-low
- in_val  input  1  input beat valid
- in_rdy  output  1  input beat ready; a beat transfers when in_val && in_rdy
- in_op  input  2  result select: 0 AND, 1 NAND, 2 OR, 3 NOR
- in_and, in_nand, in_or, in_nor  input  4 each  results from the gate block
- in_flush  input  1  close the current partial word
- out_val  output  1  packed word valid
- out_rdy  input  1  consumer ready; a word transfers when out_val && out_rdy
- out_msg  output  4*NBEATS  packed word; beat k occupies bits [4k+3:4k]
- out_count  output  $clog2(NBEATS+1)  number of valid beats in out_msg
- out_op  output  2  op of beat 0 of the word
- out_mixed  output  1  set if any later beat's op differed from beat 0's op

## Operation
- States:
  - EMPTY: count 0.
  - FILL: 1..NBEATS-1 beats held.
  - FULL: word presented.
- Accepting a beat:
  - Selected nibble = result chosen by in_op, written into slot [count].
  - count increments.
  - The first beat of a word (count 0) latches out_op and clears the mixed flag.
  - A later beat with in_op != latched op sets the mixed flag.
- Transitions:
  - EMPTY: beat accepted -> FILL. If NBEATS beats are reached or flush is set in the same cycle -> FULL.
  - FILL: the NBEATS-th beat is accepted -> FULL.
  - FILL, in_flush=1: -> FULL with the current count. If a beat is accepted in the same cycle, it is included first.
  - FULL: output fires -> EMPTY. If a beat is accepted in the same cycle, it becomes beat 0 of the new word (-> FILL, or -> FULL if NBEATS would be 1, which is illegal).
- Flush in EMPTY with no beat accepted is ignored. Flush in FULL is ignored.
- Unused slots of a flushed word read 0. Slots are cleared whenever a new word starts.
- in_rdy = (state != FULL) || out_rdy. This is combinational from out_rdy, with no combinational path from in_val.
- out_val = (state == FULL). out_msg, out_count, out_op and out_mixed are registered and stable while out_val=1 && out_rdy=0.
- Reset, at any time, including mid-word:
  - state EMPTY, count 0, all slots 0.
  - out_val 0, out_msg 0, out_count 0, out_op 0, out_mixed 0.
  - in_rdy 1.
  - Partial words are discarded.

## Timing
- Last beat (or flush) accepted at edge N: out_val=1 after edge N, usable in cycle N+1.
- Full throughput: with out_rdy held at 1, one beat is accepted every cycle with no bubble. This gives one word per NBEATS cycles.
- Backpressure: out_rdy=0 in FULL drops in_rdy to 0 in the same cycle. No beat is lost or duplicated.
- Reset deassertion takes effect at the first rising edge after reset_n rises.

## Structure
- Package bitwise_pkg holds:
  - op enum typedef: OP_AND=0, OP_NAND=1, OP_OR=2, OP_NOR=3.
  - state enum typedef: EMPTY, FILL, FULL.
  - nibble width constant: 4.
- One sub-module is natural: bitwise_result_sel, a combinational 4:1 nibble mux driven by in_op.
- Word register, counter, op/mixed flags and FSM stay in the top module.

## Test plan
- NBEATS=4, out_rdy=1, four beats with op AND where in_and = 1, 2, 3, 4 -> out_msg=16'h4321, out_count=4, out_op=0, out_mixed=0, out_val exactly one cycle after the 4th beat.
- Beats op OR (in_or=A), op NOR (in_nor=5), then flush -> out_msg=16'h005A, out_count=2, out_op=2, out_mixed=1.
- Word in FULL with out_rdy=0 for 3 cycles while in_val=1 -> in_rdy=0, out_msg held. Then out_rdy=1 -> word fires, and the same-cycle beat (NAND, in_nand=7) lands as beat 0 of the next word (slot 0 = 7, count 1).
- Flush with in_val=0 in EMPTY -> no out_val. Flush with beat 3 (in_and=F) after two beats -> out_count=3, bits [11:8]=F.
- Assert reset_n=0 after 2 beats -> all outputs 0, in_rdy=1. After release, 4 new beats produce a word containing only the new nibbles.
- Continuous stream of 12 beats with out_rdy=1 -> 3 words, no stalls (in_rdy always 1), correct nibble order.
